// File: rtl/jtmx5k_romslot.sv
// jtmx5k_romslot: graphics ROM responder with a 2-entry tag cache in front of
// the SDRAM controller. Each miss becomes one req/ack/data_rdy transaction.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   flush             invalidate both cache entries
//   addr, addr_ok     ROM word address and request valid from the graphics chip
//   dout, data_ok     ROM data and hit indication (combinational)
//   sdram_addr, req   SDRAM read address and request
//   ack, data_rdy,din SDRAM controller handshake and read data
module jtmx5k_romslot #(
    parameter int AW = 18,
    parameter int DW = 16,
    parameter int SAW = 22,
    parameter logic [SAW-1:0] OFFSET = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic [AW-1:0]  addr,
    input  logic           addr_ok,
    output logic [DW-1:0]  dout,
    output logic           data_ok,
    output logic [SAW-1:0] sdram_addr,
    output logic           req,
    input  logic           ack,
    input  logic           data_rdy,
    input  logic [DW-1:0]  din
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            valid_q, valid_d;
    logic [1:0][AW-1:0]    tag_q, tag_d;
    logic [1:0][DW-1:0]    data_q, data_d;
    logic                  next_q, next_d;
    logic                  req_q, req_d;
    logic [SAW-1:0]        sdram_addr_q, sdram_addr_d;
    logic [AW-1:0]         req_addr_q, req_addr_d;
    logic [DW-1:0]         dout_q, dout_d;
    // Set when a flush lands while a transaction is in flight, so the
    // returning data is discarded instead of cached.
    logic                  drop_q, drop_d;

    logic                  hit0, hit1, hit, fill;
    logic [DW-1:0]         hit_data;

    assign hit0     = addr_ok & valid_q[0] & (tag_q[0] == addr);
    assign hit1     = addr_ok & valid_q[1] & (tag_q[1] == addr);
    assign hit      = hit0 | hit1;
    assign hit_data = hit0 ? data_q[0] : data_q[1];

    assign data_ok    = hit;
    assign dout       = hit ? hit_data : dout_q;
    assign req        = req_q;
    assign sdram_addr = sdram_addr_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        next_d       = next_q;
        req_d        = req_q;
        sdram_addr_d = sdram_addr_q;
        req_addr_d   = req_addr_q;
        drop_d       = drop_q;
        dout_d       = hit ? hit_data : dout_q;
        fill         = 1'b0;

        case (state_q)
            IDLE: begin
                if (addr_ok && !hit) begin
                    req_addr_d   = addr;
                    sdram_addr_d = OFFSET + SAW'(addr);
                    req_d        = 1'b1;
                    drop_d       = 1'b0;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    req_d = 1'b0;
                    if (data_rdy) begin
                        fill    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (data_rdy) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // A miss guarantees req_addr matches neither tag, so no duplicate check.
        if (fill && !drop_q && !flush) begin
            valid_d[next_q] = 1'b1;
            tag_d[next_q]   = req_addr_q;
            data_d[next_q]  = din;
            next_d          = ~next_q;
        end

        // Flush wins over a same-cycle fill.
        if (flush) begin
            valid_d = '0;
            next_d  = 1'b0;
            if (state_q != IDLE) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            next_q       <= 1'b0;
            req_q        <= 1'b0;
            sdram_addr_q <= '0;
            req_addr_q   <= '0;
            dout_q       <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            next_q       <= next_d;
            req_q        <= req_d;
            sdram_addr_q <= sdram_addr_d;
            req_addr_q   <= req_addr_d;
            dout_q       <= dout_d;
            drop_q       <= drop_d;
        end
    end

endmodule
